// File: rtl/mul_calculate_pkg.sv
// -----------------------------------------------------------------------------
// mul_calculate_pkg
//   Constants shared by the iterative multiplier and its companion divider.
//   MUL_WIDTH : operand width (product is 2*MUL_WIDTH bits)
//   MUL_ITERS : number of shift-add iterations per operation
//   MUL_CNT_W : width of the iteration counter
// -----------------------------------------------------------------------------
package mul_calculate_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = 32;
  localparam int MUL_CNT_W = 5;

  typedef logic [MUL_CNT_W-1:0] mul_cnt_t;

endpackage : mul_calculate_pkg

// File: rtl/mul_calculate_twos_abs.sv
// -----------------------------------------------------------------------------
// twos_abs
//   Conditional two's-complement negate. Used both to take operand magnitudes
//   and to re-apply the sign to the double-width product.
//   Ports:
//     i_neg  1      1 = output the two's-complement negation of i_val
//     i_val  WIDTH  input value
//     o_val  WIDTH  i_neg ? -i_val : i_val  (modulo 2^WIDTH)
// -----------------------------------------------------------------------------
module twos_abs #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Negating zero wraps back to zero, so no negative zero can appear.
  assign o_val = i_neg ? (~i_val + ONE) : i_val;

endmodule : twos_abs

// File: rtl/mul_calculate.sv
// -----------------------------------------------------------------------------
// mul_calculate
//   Iterative radix-2 shift-add multiplier for MULT/MULTU. Signed operands are
//   reduced to magnitudes, multiplied unsigned over 32 iterations, and the
//   product sign is re-applied combinationally on the output path.
//   Ports:
//     clk           system clock, rising edge
//     rst           synchronous reset, active-high
//     start         one-cycle pulse: sample operands and (re)start a multiply
//     signed_mul    1 = MULT (two's complement), 0 = MULTU
//     multiplicand  operand A, sampled only on a start edge
//     multiplier    operand B, sampled only on a start edge
//     hi            product[2*WIDTH-1:WIDTH], sign-corrected
//     lo            product[WIDTH-1:0], sign-corrected
//     mul_done      1 = idle / result valid, 0 = busy
// -----------------------------------------------------------------------------
module mul_calculate
  import mul_calculate_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mul,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mul_done
);

  localparam mul_cnt_t CNT_LAST = MUL_CNT_W'(MUL_ITERS - 1);
  localparam mul_cnt_t CNT_ONE  = MUL_CNT_W'(1);

  // Control and datapath state.
  logic             r_busy;
  mul_cnt_t         r_cnt;
  logic             r_neg;
  logic [WIDTH:0]   r_acc_hi;   // extra bit holds the carry of each add
  logic [WIDTH-1:0] r_acc_lo;   // multiplier bits shift out, product bits in
  logic [WIDTH-1:0] r_mcand;

  logic [WIDTH-1:0]   w_mcand_abs;
  logic [WIDTH-1:0]   w_mplier_abs;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH+1:0]   w_sum;
  logic [2*WIDTH-1:0] w_prod_raw;
  logic [2*WIDTH-1:0] w_prod;

  // Operand magnitudes; MULTU passes the raw operands through. A signed
  // 0x80000000 negates to itself, which read unsigned is the right magnitude.
  twos_abs #(.WIDTH(WIDTH)) u_abs_mcand (
    .i_neg (signed_mul & multiplicand[WIDTH-1]),
    .i_val (multiplicand),
    .o_val (w_mcand_abs)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_mplier (
    .i_neg (signed_mul & multiplier[WIDTH-1]),
    .i_val (multiplier),
    .o_val (w_mplier_abs)
  );

  // One shift-add step: add the multiplicand when the current multiplier bit
  // (the LSB of acc_lo) is set, then shift the whole accumulator right.
  assign w_addend = r_acc_lo[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_acc_hi} + {2'b00, w_addend};

  always_ff @(posedge clk) begin
    // NOTE: every state register here uses non-blocking assignment so all of
    // them update from the same pre-edge values; blocking would chain them.
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_neg    <= signed_mul & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      r_acc_hi <= '0;
      r_acc_lo <= w_mplier_abs;
    end else if (r_busy) begin
      // {acc_hi, acc_lo} <= {sum, acc_lo} >> 1
      r_acc_hi <= w_sum[WIDTH+1:1];
      r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
      r_cnt    <= r_cnt + CNT_ONE;
      if (r_cnt == CNT_LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  // NOTE: r_mcand is only read while busy, and every busy period begins with a
  // start that loads it, so it is deliberately kept out of reset.
  always_ff @(posedge clk) begin
    if (start) begin
      r_mcand <= w_mcand_abs;
    end
  end

  // Sign correction is a full-width negate so the carry crosses HI/LO.
  assign w_prod_raw = {r_acc_hi[WIDTH-1:0], r_acc_lo};

  twos_abs #(.WIDTH(2*WIDTH)) u_sign_prod (
    .i_neg (r_neg),
    .i_val (w_prod_raw),
    .o_val (w_prod)
  );

  assign hi       = w_prod[2*WIDTH-1:WIDTH];
  assign lo       = w_prod[WIDTH-1:0];
  assign mul_done = ~r_busy;

endmodule : mul_calculate

// File: tb/tb_mul_calculate.sv
// -----------------------------------------------------------------------------
// tb_mul_calculate
//   Directed self-checking bench for mul_calculate. Inputs are driven 1 time
//   unit after the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mul_calculate;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mul;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_done;

  int errors;
  int checks;

  mul_calculate dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mul   (signed_mul),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .hi           (hi),
    .lo           (lo),
    .mul_done     (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for exactly one rising edge with the given operands.
  task automatic do_start(input logic sm, input logic [31:0] a, input logic [31:0] b);
    signed_mul   = sm;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // Counts edges after the start edge until mul_done is seen high; gives up
  // after 100 edges and returns -1.
  task automatic wait_done(output int n);
    n = 0;
    while (mul_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (mul_done !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    logic stable;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || mul_done !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h done=%b, want hi=0 lo=0 done=1", hi, lo, mul_done);
    end
    rst    = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hi !== 32'h0 || lo !== 32'h0 || mul_done !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: hi=%h lo=%h done=%b, want hi=0 lo=0 done=1", hi, lo, mul_done);
    end
  endtask

  task automatic test_unsigned();
    int n;
    do_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL unsigned_latency: got %0d cycles, want 32", n);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++;
      $display("FAIL unsigned_max: got %h_%h, want fffffffe_00000001", hi, lo);
    end
    // Operands change without start: result must hold.
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h0000_0002;
    signed_mul   = 1'b1;
    repeat (5) tick();
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001 || mul_done !== 1'b1) begin
      errors++;
      $display("FAIL result_hold: got %h_%h done=%b, want fffffffe_00000001 done=1", hi, lo, mul_done);
    end
  endtask

  task automatic test_signed_mixed();
    int n;
    do_start(1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done(n);
    checks++;
    if (n !== 32 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL signed_neg3x7: got %h_%h after %0d, want ffffffff_ffffffeb after 32", hi, lo, n);
    end
    do_start(1'b0, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done(n);
    checks++;
    if (n !== 32 || hi !== 32'h0000_0006 || lo !== 32'hFFFF_FFEB) begin
      errors++;
      $display("FAIL unsigned_fffffffdx7: got %h_%h after %0d, want 00000006_ffffffeb after 32", hi, lo, n);
    end
    // Negative times positive with both magnitudes > 1: -6 * 5 = -30
    do_start(1'b1, 32'h0000_0005, 32'hFFFF_FFFA);
    wait_done(n);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFE2) begin
      errors++;
      $display("FAIL signed_5xneg6: got %h_%h, want ffffffff_ffffffe2", hi, lo);
    end
    // -4 * -9 = 36
    do_start(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF7);
    wait_done(n);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0000_0024) begin
      errors++;
      $display("FAIL signed_neg4xneg9: got %h_%h, want 00000000_00000024", hi, lo);
    end
  endtask

  task automatic test_signed_extreme();
    int n;
    do_start(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    checks++;
    if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin
      errors++;
      $display("FAIL signed_min_sq: got %h_%h, want 40000000_00000000", hi, lo);
    end
    do_start(1'b1, 32'h8000_0000, 32'h0000_0001);
    wait_done(n);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'h8000_0000) begin
      errors++;
      $display("FAIL signed_min_x1: got %h_%h, want ffffffff_80000000", hi, lo);
    end
    // Zero with a negative operand: no negative zero.
    do_start(1'b1, 32'h0000_0000, 32'hFFFF_FFFB);
    wait_done(n);
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL signed_zero: got %h_%h, want 00000000_00000000", hi, lo);
    end
  endtask

  task automatic test_restart();
    int n;
    do_start(1'b0, 32'd100, 32'd100);
    repeat (9) tick();
    checks++;
    if (mul_done !== 1'b0) begin
      errors++;
      $display("FAIL restart_busy: done=%b, want 0", mul_done);
    end
    do_start(1'b0, 32'd6, 32'd7);
    wait_done(n);
    checks++;
    if (n !== 32 || hi !== 32'h0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL restart_result: got %h_%h after %0d, want 00000000_0000002a after 32", hi, lo, n);
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    do_start(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (15) tick();
    checks++;
    if (mul_done !== 1'b0) begin
      errors++;
      $display("FAIL midop_busy: done=%b, want 0", mul_done);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (mul_done !== 1'b1 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL midop_reset: got %h_%h done=%b, want 0_0 done=1", hi, lo, mul_done);
    end
    rst = 1'b0;
    tick();
    do_start(1'b0, 32'd3, 32'd5);
    wait_done(n);
    checks++;
    if (n !== 32 || hi !== 32'h0 || lo !== 32'd15) begin
      errors++;
      $display("FAIL after_reset_mul: got %h_%h after %0d, want 00000000_0000000f after 32", hi, lo, n);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    signed_mul   = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #1;
    test_reset();
    test_unsigned();
    test_signed_mixed();
    test_signed_extreme();
    test_restart();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mul_calculate
